// File: rtl/pci_target.sv
// pci_target: PCI memory target for an 8x32-bit window, with linear bursts, byte enables,
// initiator wait states and a STOP# disconnect when a burst runs off the end of the window.
module pci_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  logic [31:0] AD,
  input  logic [3:0]  C_BE,
  input  logic        frame,
  input  logic        irdy,
  output logic        trdy,
  output logic        devsel,
  output logic        stop
);
  typedef enum logic [2:0] {IDLE, W_DATA, R_TURN, R_DATA, DISC, BACKOFF} state_t;
  state_t      state;
  logic [2:0]  ptr;
  logic [2:0]  ptr_nx;
  logic [31:0] mem [8];
  logic [31:0] ad_q;
  logic        frame_q;
  logic        addr_phase;
  logic        hit;
  logic        xfer;
  assign ptr_nx = ptr + 3'd1;
  assign addr_phase = state == IDLE && !frame && frame_q;
  assign hit = AD[31:5] == BASE_ADDR[31:5] && AD[1:0] == 2'b00;
  assign xfer = (state == W_DATA || state == R_DATA) && !irdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      ad_q <= '0;
      frame_q <= 1'b1;
      for (int i = 0; i < 8; i++)
        mem[i] <= '0;
    end else begin
      frame_q <= frame;
      case (state)
        IDLE:
          if (addr_phase && hit && C_BE[3:1] == 3'b011) begin
            state <= C_BE[0] ? W_DATA : R_TURN;
            ptr <= AD[4:2];
          end
        R_TURN: begin
          state <= R_DATA;
          ad_q <= mem[ptr];
        end
        W_DATA, R_DATA:
          if (xfer) begin
            if (state == W_DATA)
              for (int i = 0; i < 4; i++)
                if (!C_BE[i])
                  mem[ptr][8*i +: 8] <= AD[8*i +: 8];
            if (frame)
              state <= BACKOFF;
            else if (ptr == 3'd7)
              state <= DISC;
            else begin
              ptr <= ptr_nx;
              ad_q <= mem[ptr_nx];
            end
          end
        DISC:
          if (frame)
            state <= BACKOFF;
        default:
          state <= IDLE;
      endcase
    end
  assign devsel = state == IDLE ? 1'bz : state == BACKOFF;
  assign trdy   = state == IDLE ? 1'bz : !(state == W_DATA || state == R_DATA);
  assign stop   = state == IDLE ? 1'bz : state != DISC;
  assign AD     = state == R_DATA ? ad_q : 32'bz;
endmodule

// File: tb/tb_pci_target.sv
// tb_pci_target: directed bench for pci_target; bus lines carry pull-ups, so a released line reads 1.
module tb_pci_target;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  c_be = 4'hf;
  logic        frame = 1;
  logic        irdy = 1;
  logic        ad_oe = 0;
  logic [31:0] ad_drv = '0;
  tri1 [31:0]  ad;
  tri1         trdy;
  tri1         devsel;
  tri1         stop;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] wr_data [8];
  logic [31:0] exp_w [8];

  assign ad = ad_oe ? ad_drv : 32'bz;

  pci_target dut (
    .clk(clk), .rst_n(rst_n), .AD(ad), .C_BE(c_be), .frame(frame),
    .irdy(irdy), .trdy(trdy), .devsel(devsel), .stop(stop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input int n, input logic [3:0] be,
                          input int wait_at, input string tag);
    frame = 0; ad_oe = 1; ad_drv = addr; c_be = 4'b0111; irdy = 1;
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b001) begin
      fails++;
      $display("FAIL %s claim: dts=%b exp=001", tag, {devsel, trdy, stop});
    end
    for (int k = 0; k < n; k++) begin
      if (k == wait_at) begin
        irdy = 1; ad_drv = 32'h5A5A_5A5A; c_be = 4'h0; frame = 0;
        tick;
        tick;
        checks++;
        if ({devsel, trdy, stop} !== 3'b001) begin
          fails++;
          $display("FAIL %s wait hold: dts=%b exp=001", tag, {devsel, trdy, stop});
        end
      end
      irdy = 0; ad_drv = wr_data[k]; c_be = be; frame = (k == n - 1);
      tick;
    end
    irdy = 1; ad_oe = 0; c_be = 4'hf;
    #1;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111 || ad !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL %s backoff: dts=%b ad=%h exp=111/ffffffff", tag, {devsel, trdy, stop}, ad);
    end
    tick;
  endtask

  task automatic do_read(input logic [31:0] addr, input int n, input int wait_at, input string tag);
    frame = 0; ad_oe = 1; ad_drv = addr; c_be = 4'b0110; irdy = 1;
    tick;
    ad_oe = 0; c_be = 4'h0; irdy = 0; frame = (n == 1);
    #1;
    checks++;
    if ({devsel, trdy, stop} !== 3'b011 || ad !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL %s turnaround: dts=%b ad=%h exp=011/ffffffff", tag, {devsel, trdy, stop}, ad);
    end
    tick;
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({devsel, trdy, stop} !== 3'b001 || ad !== exp_w[k]) begin
        fails++;
        $display("FAIL %s word%0d: dts=%b ad=%h exp=001/%h", tag, k, {devsel, trdy, stop}, ad, exp_w[k]);
      end
      if (k == wait_at) begin
        irdy = 1;
        tick;
        tick;
        checks++;
        if (trdy !== 1'b0 || ad !== exp_w[k]) begin
          fails++;
          $display("FAIL %s wait word%0d: trdy=%b ad=%h exp=0/%h", tag, k, trdy, ad, exp_w[k]);
        end
      end
      irdy = 0; frame = (k == n - 1);
      tick;
    end
    irdy = 1; c_be = 4'hf;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111 || ad !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL %s backoff: dts=%b ad=%h exp=111/ffffffff", tag, {devsel, trdy, stop}, ad);
    end
    tick;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111 || ad !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL reset outputs: dts=%b ad=%h exp=111/ffffffff", {devsel, trdy, stop}, ad);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick;
    exp_w[0] = 32'h0;
    do_read(32'h0000_011C, 1, -1, "reset_mem7");
  endtask

  task automatic test_single_write;
    wr_data[0] = 32'hDEAD_BEEF;
    do_write(32'h0000_0108, 1, 4'h0, -1, "single_wr");
    checks++;
    if ({devsel, trdy, stop} !== 3'b111 || ad !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL single_wr idle: dts=%b ad=%h exp=111/ffffffff", {devsel, trdy, stop}, ad);
    end
    exp_w[0] = 32'hDEAD_BEEF;
    do_read(32'h0000_0108, 1, -1, "single_rd");
  endtask

  task automatic test_byte_enable;
    wr_data[0] = 32'h1122_3344;
    do_write(32'h0000_0100, 1, 4'h0, -1, "be_full");
    wr_data[0] = 32'hAABB_CCDD;
    do_write(32'h0000_0100, 1, 4'b1010, -1, "be_part");
    exp_w[0] = 32'h11BB_33DD;
    do_read(32'h0000_0100, 1, -1, "be_rd");
  endtask

  task automatic test_burst_waits;
    wr_data[0] = 32'hA1A1_0001; wr_data[1] = 32'hB2B2_0002; wr_data[2] = 32'hC3C3_0003;
    do_write(32'h0000_0104, 3, 4'h0, 1, "wr_burst");
    exp_w[0] = 32'h11BB_33DD; exp_w[1] = 32'hA1A1_0001;
    exp_w[2] = 32'hB2B2_0002; exp_w[3] = 32'hC3C3_0003;
    do_read(32'h0000_0100, 4, 1, "rd_burst");
  endtask

  task automatic test_disconnect;
    frame = 0; ad_oe = 1; ad_drv = 32'h0000_0118; c_be = 4'b0111; irdy = 1;
    tick;
    irdy = 0; c_be = 4'h0; ad_drv = 32'h6666_0006;
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b001) begin
      fails++;
      $display("FAIL disc word6: dts=%b exp=001", {devsel, trdy, stop});
    end
    ad_drv = 32'h7777_0007;
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b010) begin
      fails++;
      $display("FAIL disc assert: dts=%b exp=010", {devsel, trdy, stop});
    end
    ad_drv = 32'h8888_0008;
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b010) begin
      fails++;
      $display("FAIL disc hold: dts=%b exp=010", {devsel, trdy, stop});
    end
    frame = 1; irdy = 1; ad_oe = 0; c_be = 4'hf;
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111) begin
      fails++;
      $display("FAIL disc backoff: dts=%b exp=111", {devsel, trdy, stop});
    end
    tick;
    exp_w[0] = 32'h6666_0006; exp_w[1] = 32'h7777_0007;
    do_read(32'h0000_0118, 2, -1, "disc_rd67");
    exp_w[0] = 32'h11BB_33DD; exp_w[1] = 32'hA1A1_0001;
    do_read(32'h0000_0100, 2, -1, "disc_rd01");
  endtask

  task automatic test_miss;
    logic [35:0] cases [3];
    cases[0] = {32'h0000_0200, 4'b0111};
    cases[1] = {32'h0000_0100, 4'b0010};
    cases[2] = {32'h0000_0101, 4'b0111};
    for (int i = 0; i < 3; i++) begin
      frame = 0; ad_oe = 1; ad_drv = cases[i][35:4]; c_be = cases[i][3:0]; irdy = 1;
      tick;
      checks++;
      if ({devsel, trdy, stop} !== 3'b111) begin
        fails++;
        $display("FAIL miss%0d addr: dts=%b exp=111", i, {devsel, trdy, stop});
      end
      ad_drv = 32'hFFFF_0000; c_be = 4'h0; irdy = 0; frame = 1;
      tick;
      checks++;
      if ({devsel, trdy, stop} !== 3'b111) begin
        fails++;
        $display("FAIL miss%0d data: dts=%b exp=111", i, {devsel, trdy, stop});
      end
      irdy = 1; ad_oe = 0; c_be = 4'hf;
      tick;
    end
    exp_w[0] = 32'h11BB_33DD;
    do_read(32'h0000_0100, 1, -1, "miss_mem0");
  endtask

  task automatic test_back_to_back;
    frame = 0; ad_oe = 1; ad_drv = 32'h0000_0104; c_be = 4'b0111; irdy = 1;
    tick;
    irdy = 0; c_be = 4'h0; ad_drv = 32'hDEAD_0001; frame = 1;
    tick;
    frame = 0; irdy = 1; ad_drv = 32'h0000_010C; c_be = 4'b0111;
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111) begin
      fails++;
      $display("FAIL b2b in backoff: dts=%b exp=111", {devsel, trdy, stop});
    end
    tick;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111) begin
      fails++;
      $display("FAIL b2b no edge: dts=%b exp=111", {devsel, trdy, stop});
    end
    frame = 1; ad_oe = 0; c_be = 4'hf;
    tick;
    exp_w[0] = 32'hDEAD_0001; exp_w[1] = 32'hB2B2_0002; exp_w[2] = 32'hC3C3_0003;
    do_read(32'h0000_0104, 3, -1, "b2b_rd");
  endtask

  task automatic test_reset_mid_burst;
    frame = 0; ad_oe = 1; ad_drv = 32'h0000_0104; c_be = 4'b0110; irdy = 1;
    tick;
    ad_oe = 0; c_be = 4'h0; irdy = 0;
    tick;
    checks++;
    if (ad !== 32'hDEAD_0001 || trdy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid rdata: ad=%h trdy=%b exp=dead0001/0", ad, trdy);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({devsel, trdy, stop} !== 3'b111 || ad !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL rst_mid async: dts=%b ad=%h exp=111/ffffffff", {devsel, trdy, stop}, ad);
    end
    frame = 1; irdy = 1; c_be = 4'hf;
    @(negedge clk);
    rst_n = 1;
    tick;
    exp_w[0] = 32'h0;
    do_read(32'h0000_0104, 1, -1, "rst_rd1");
    exp_w[0] = 32'h0; exp_w[1] = 32'h0;
    do_read(32'h0000_0118, 2, -1, "rst_rd67");
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_byte_enable;
    test_burst_waits;
    test_disconnect;
    test_miss;
    test_back_to_back;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
